// File: rtl/sched_pkg.sv
// ----------------------------------------------------------------------------
// sched_pkg
// Shared types and helpers for the timed round-robin scheduler.
//   sched_state_e : two-state session FSM encoding (IDLE / GRANT)
//   idx_w()       : width of an index into a set of n items (at least 1 bit)
// ----------------------------------------------------------------------------
package sched_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } sched_state_e;

    // Width needed to hold values 0..n-1; never returns 0 so that a
    // degenerate count still yields a legal vector width.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : sched_pkg

// File: rtl/rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Finds the first set request bit in the
// order ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
// Ports:
//   req     [N]   request vector
//   ptr     [IW]  highest-priority index (must be < N)
//   pick    [N]   one-hot winner, all-zero when no request
//   pick_id [IW]  index of the winner, 0 when no request
//   any           high when any request bit is set
// ----------------------------------------------------------------------------
module rr_pick
    import sched_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  pick,
    output logic [IW-1:0] pick_id,
    output logic          any
);

    // Concatenating the request vector with itself and shifting right by ptr
    // puts the search order into bit order: bit 0 of the window is req[ptr],
    // bit N-1 is req[ptr-1] after wrap.
    logic [2*N-1:0] dbl;
    logic [N-1:0]   win;
    logic [N:0]     seen;
    logic [N-1:0]   first;
    logic [IW-1:0]  off;
    logic [IW:0]    sum;
    logic [IW:0]    sum_wrapped;

    assign dbl = {req, req};
    assign win = N'(dbl >> ptr);

    // Lowest set bit of the window via a running "already seen" chain.
    assign seen[0] = 1'b0;
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_first
            assign seen[gi+1] = seen[gi] | win[gi];
            assign first[gi]  = win[gi] & ~seen[gi];
        end
    endgenerate

    always_comb begin
        off = '0;
        for (int i = 0; i < N; i++) begin
            if (first[i]) begin
                off = IW'(i);
            end
        end
    end

    // Map the window offset back to an absolute index, modulo N.
    assign sum         = {1'b0, ptr} + {1'b0, off};
    assign sum_wrapped = (sum >= (IW+1)'(N)) ? (sum - (IW+1)'(N)) : sum;

    assign any     = |req;
    assign pick_id = any ? sum_wrapped[IW-1:0] : '0;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_pick
            assign pick[gi] = any && (pick_id == IW'(gi));
        end
    endgenerate

endmodule : rr_pick

// File: rtl/timed_rr_scheduler.sv
// ----------------------------------------------------------------------------
// timed_rr_scheduler
// Session-based round-robin arbiter for one shared resource. A grant is held
// until the owner pulses done, drops its request, or the hold watchdog runs
// out after MAX_HOLD grant cycles. Every release is followed by one idle
// cycle before the next arbitration.
// Ports:
//   clk       clock, rising edge
//   rst       synchronous active-high reset
//   req  [N]  per-requester request level
//   done      session-finished strobe from the current owner
//   grant[N]  registered one-hot select, zero when idle
//   grant_id  index of the current owner, 0 when idle
//   busy      high while a grant is active
//   timeout   one-cycle pulse when the watchdog ends a session
// ----------------------------------------------------------------------------
module timed_rr_scheduler
    import sched_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_HOLD = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N-1:0]          req,
    input  logic                  done,
    output logic [N-1:0]          grant,
    output logic [idx_w(N)-1:0]   grant_id,
    output logic                  busy,
    output logic                  timeout
);

    localparam int IW = idx_w(N);
    localparam int HW = idx_w(MAX_HOLD);

    sched_state_e  state_q;
    logic [IW-1:0] ptr_q;
    logic [HW-1:0] hold_cnt_q;
    logic [N-1:0]  grant_q;
    logic [IW-1:0] grant_id_q;
    logic          busy_q;
    logic          timeout_q;

    logic [N-1:0]  pick;
    logic [IW-1:0] pick_id;
    logic          pick_any;

    logic          owner_req;
    logic          hold_expired;
    logic          release_d;
    logic          wd_fire_d;
    logic [IW-1:0] ptr_d;

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req     (req),
        .ptr     (ptr_q),
        .pick    (pick),
        .pick_id (pick_id),
        .any     (pick_any)
    );

    always_comb begin
        owner_req    = req[grant_id_q];
        hold_expired = (hold_cnt_q == HW'(MAX_HOLD - 1));
        release_d    = done | ~owner_req | hold_expired;
        // done wins a tie with the watchdog: that is a normal finish.
        wd_fire_d    = hold_expired & ~done & owner_req;
        ptr_d        = (grant_id_q == IW'(N - 1)) ? '0 : grant_id_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
            grant_q    <= '0;
            grant_id_q <= '0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        grant_q    <= pick;
                        grant_id_q <= pick_id;
                        busy_q     <= 1'b1;
                        hold_cnt_q <= '0;
                        state_q    <= GRANT;
                    end
                end
                GRANT: begin
                    if (release_d) begin
                        grant_q    <= '0;
                        grant_id_q <= '0;
                        busy_q     <= 1'b0;
                        ptr_q      <= ptr_d;
                        timeout_q  <= wd_fire_d;
                        state_q    <= IDLE;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign grant    = grant_q;
    assign grant_id = grant_id_q;
    assign busy     = busy_q;
    assign timeout  = timeout_q;

endmodule : timed_rr_scheduler

// File: tb/tb_timed_rr_scheduler.sv
// ----------------------------------------------------------------------------
// tb_timed_rr_scheduler
// Directed self-checking bench for timed_rr_scheduler with N=4, MAX_HOLD=4.
// Each step drives inputs for one edge and queues the outputs expected after
// that edge; the queue entry is popped and compared once the edge has passed.
// ----------------------------------------------------------------------------
module tb_timed_rr_scheduler;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       busy;
    logic       timeout;

    int checks;
    int errors;

    typedef struct {
        logic [3:0] grant;
        logic       timeout;
        string      tag;
    } exp_t;

    exp_t sb[$];

    timed_rr_scheduler #(
        .N        (4),
        .MAX_HOLD (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .done     (done),
        .grant    (grant),
        .grant_id (grant_id),
        .busy     (busy),
        .timeout  (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] id_of(input logic [3:0] g);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (g[i]) r = 2'(i);
        end
        return r;
    endfunction

    // Drive one edge worth of inputs, queue the expectation, then check it.
    task automatic step(input logic rs, input logic [3:0] r, input logic d,
                        input logic [3:0] eg, input logic et, input string tag);
        exp_t e;
        exp_t got;
        rst  = rs;
        req  = r;
        done = d;
        e.grant   = eg;
        e.timeout = et;
        e.tag     = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        checks++;
        assert (grant === got.grant) else begin
            errors++;
            $error("FAIL %s grant got %b want %b", got.tag, grant, got.grant);
        end
        checks++;
        assert (grant_id === id_of(got.grant)) else begin
            errors++;
            $error("FAIL %s grant_id got %0d want %0d", got.tag, grant_id, id_of(got.grant));
        end
        checks++;
        assert (busy === (|got.grant)) else begin
            errors++;
            $error("FAIL %s busy got %b want %b", got.tag, busy, |got.grant);
        end
        checks++;
        assert (timeout === got.timeout) else begin
            errors++;
            $error("FAIL %s timeout got %b want %b", got.tag, timeout, got.timeout);
        end
        $display("step %-12s rst=%b req=%b done=%b -> grant=%b id=%0d busy=%b timeout=%b",
                 got.tag, rs, r, d, grant, grant_id, busy, timeout);
    endtask

    task automatic check_ptr(input logic [1:0] exp_ptr, input string tag);
        checks++;
        assert (dut.ptr_q === exp_ptr) else begin
            errors++;
            $error("FAIL %s ptr got %0d want %0d", tag, dut.ptr_q, exp_ptr);
        end
        $display("ptr   %-12s ptr=%0d", tag, dut.ptr_q);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst  = 1'b1;
        req  = 4'b1111;
        done = 1'b0;

        // Reset held for two edges with every requester active.
        step(1, 4'b1111, 0, 4'b0000, 0, "rst0");
        step(1, 4'b1111, 0, 4'b0000, 0, "rst1");
        check_ptr(2'd0, "rst_ptr");
        step(0, 4'b1111, 0, 4'b0001, 0, "first_gnt");
        step(0, 4'b1111, 1, 4'b0000, 0, "first_rel");
        check_ptr(2'd1, "first_ptr");
        step(0, 4'b0000, 0, 4'b0000, 0, "idle");

        // Single session: two grant cycles, done on the third edge.
        step(0, 4'b0100, 0, 4'b0100, 0, "sgl_gnt");
        step(0, 4'b0100, 0, 4'b0100, 0, "sgl_hold");
        step(0, 4'b0100, 1, 4'b0000, 0, "sgl_done");
        check_ptr(2'd3, "sgl_ptr");

        // Wrap from ptr=3 and alternate between requesters 0 and 1.
        step(0, 4'b0011, 0, 4'b0001, 0, "wrap_g0");
        step(0, 4'b0011, 1, 4'b0000, 0, "wrap_r0");
        step(0, 4'b0011, 0, 4'b0010, 0, "wrap_g1");
        step(0, 4'b0011, 1, 4'b0000, 0, "wrap_r1");
        step(0, 4'b0011, 0, 4'b0001, 0, "wrap_g0b");
        step(0, 4'b0011, 1, 4'b0000, 0, "wrap_r0b");
        check_ptr(2'd1, "wrap_ptr");

        // Watchdog: four grant cycles then a timeout pulse on the fall.
        step(0, 4'b1000, 0, 4'b1000, 0, "wd_c1");
        step(0, 4'b1000, 0, 4'b1000, 0, "wd_c2");
        step(0, 4'b1000, 0, 4'b1000, 0, "wd_c3");
        step(0, 4'b1000, 0, 4'b1000, 0, "wd_c4");
        step(0, 4'b1000, 0, 4'b0000, 1, "wd_fire");
        check_ptr(2'd0, "wd_ptr");
        step(0, 4'b1000, 0, 4'b1000, 0, "wd_regrant");

        // Withdrawal in the second grant cycle.
        step(0, 4'b1000, 0, 4'b1000, 0, "wdr_hold");
        step(0, 4'b0000, 0, 4'b0000, 0, "wdr_drop");
        check_ptr(2'd0, "wdr_ptr");

        // done coincides with hold_cnt at its limit: no timeout.
        step(0, 4'b0100, 0, 4'b0100, 0, "tie_c1");
        step(0, 4'b0100, 0, 4'b0100, 0, "tie_c2");
        step(0, 4'b0100, 0, 4'b0100, 0, "tie_c3");
        step(0, 4'b0100, 0, 4'b0100, 0, "tie_c4");
        step(0, 4'b0100, 1, 4'b0000, 0, "tie_done");
        check_ptr(2'd3, "tie_ptr");

        // Reset in the middle of a session clears grant and pointer.
        step(0, 4'b0010, 0, 4'b0010, 0, "mid_gnt");
        step(1, 4'b0010, 0, 4'b0000, 0, "mid_rst");
        check_ptr(2'd0, "mid_ptr");
        step(0, 4'b0110, 0, 4'b0010, 0, "mid_regnt");
        step(0, 4'b0110, 1, 4'b0000, 0, "mid_rel");
        check_ptr(2'd2, "mid_ptr2");
        step(0, 4'b0110, 0, 4'b0100, 0, "mid_next");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_timed_rr_scheduler

// File: doc/timed_rr_scheduler.md
# timed_rr_scheduler

Round-robin scheduler that shares one resource among N requesters on a session basis. Each grant is held for a whole session. A session ends on the `done` strobe, when the owner withdraws its request, or when a hold-time watchdog expires. This keeps one requester from monopolising the resource. The block sits between the requester ports and the shared resource and drives its one-hot select.

## Interface
- `N`, default 4: number of requesters, N ≥ 2.
- `MAX_HOLD`, default 16: maximum session length in grant cycles, MAX_HOLD ≥ 2.
- `clk`  in  1: clock; all logic on rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `req`  in  N: per-requester request level; must stay high for the whole session.
- `done`  in  1: session-finished strobe from the current owner; ignored when no grant is active.
- `grant`  out  N: one-hot grant, all-zero when idle; registered.
- `grant_id`  out  $clog2(N): index of the current owner; 0 when idle.
- `busy`  out  1: high while any grant bit is high.
- `timeout`  out  1: one-cycle pulse when the watchdog ends a session.

## Operation
- State `ptr` holds the highest-priority index. Search order is ptr, ptr+1, …, N-1, 0, …, ptr-1, with modulo-N wrap.
- FSM IDLE:
  - At an edge where `req` ≠ 0: grant the first set bit in search order, load `grant_id`, clear `hold_cnt`, and go to GRANT.
  - Otherwise stay in IDLE.
- FSM GRANT, evaluated at every edge with id = `grant_id`:
  - A release condition is any of: `done`=1, `req[id]`=0, or `hold_cnt`=MAX_HOLD-1.
  - On release: `grant` goes to 0, `busy` goes to 0, `grant_id` goes to 0, `ptr` becomes (id+1) mod N, and the FSM returns to IDLE.
  - Also on release: `timeout` is 1 only if `hold_cnt`=MAX_HOLD-1 and `done`=0 and `req[id]`=1.
  - With no release condition: `hold_cnt` increments and the grant is held.
- Simultaneous `done` and watchdog expiry count as a normal finish, so no timeout pulse is generated.
- Requests from non-owners never pre-empt the owner.
- `hold_cnt` width is $clog2(MAX_HOLD). It never wraps because release occurs at MAX_HOLD-1.
- `ptr` advances only on release, never while idle. A requester left waiting after a release therefore gains priority.

## Timing
- Reset values (edge with `rst`=1): state IDLE, `ptr`=0, `hold_cnt`=0, `grant`=0, `grant_id`=0, `busy`=0, `timeout`=0. Reset overrides any active session in the same edge.
- Grant latency: `req` sampled at edge k, so `grant` is high after edge k; this gives 1 cycle from request to grant.
- Session length: `grant` is high for 1 to MAX_HOLD cycles.
- Release latency: `done` sampled at edge k, so `grant` is low after edge k.
- Turnaround: after every release `grant` is all-zero for exactly one cycle, because IDLE arbitrates at the next edge. Back-to-back sessions are therefore separated by one idle cycle, even when the same requester re-wins.
- `timeout` rises at the same edge that `grant` falls and lasts one cycle.
- `busy` equals |`grant` in every cycle.

## Structure
- Package `sched_pkg`:
  - state enum `sched_state_e` {IDLE, GRANT};
  - helper function for the index width.
- Sub-module `rr_pick`: purely combinational.
  - Inputs: `req`[N], `ptr`.
  - Outputs: one-hot `pick`, `pick_id`, `any`.
  - Implementation: double-width rotate-and-mask.
  - `timed_rr_scheduler` instantiates it once and registers its outputs.

## Test plan
All scenarios use N=4, MAX_HOLD=4.
- **Reset:** hold `rst`=1 for 2 edges with `req`=4'b1111 → `grant`=0, `busy`=0, `timeout`=0, `grant_id`=0. After release, the first grant is 4'b0001.
- **Single session:** `req`=4'b0100, then `done` pulsed after 2 grant cycles → `grant`=4'b0100 from edge+1 for 2 cycles, then 0. Internal `ptr`=3, no timeout.
- **Wrap and fairness:** with `ptr`=3 and `req`=4'b0011 held, pulse `done` each session → grants 4'b0001, then one idle cycle, then 4'b0010, then one idle cycle, then 4'b0001.
- **Watchdog:** `req`=4'b1000 held, `done` never asserted → `grant`=4'b1000 for exactly 4 cycles. A `timeout` pulse coincides with the fall. After one idle cycle, 4'b1000 is granted again.
- **Withdrawal and tie:**
  - Owner drops `req` in its 2nd grant cycle → `grant` falls at that edge with no timeout.
  - Separately, `done` asserted in the cycle `hold_cnt`=3 → no timeout.
- **Mid-session reset:** assert `rst` while `grant`=4'b0010 → `grant`=0 after that edge and `ptr`=0. With `req`=4'b0110 the next grant is 4'b0010.
